bp_fe_icache_mem_responder: RTL and testbench



---
 rtl/bp_me_pkg.sv | 58 +++++
 rtl/bp_fe_icache_mem_responder_storage.sv | 37 +++
 rtl/bp_fe_icache_mem_responder.sv | 75 +++++++
 tb/tb_bp_fe_icache_mem_responder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_pkg.sv
// bp_me_pkg: BedRock lite mem types, responder state enum and byte-lane helpers
package bp_me_pkg;
  localparam int paddr_width_gp = 40;
  localparam int cce_block_width_gp = 512;
  localparam int block_bytes_gp = cce_block_width_gp / 8;
  localparam int lg_block_bytes_gp = $clog2(block_bytes_gp);
  localparam int mem_payload_width_gp = 16;
  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'b0000,
    e_bedrock_mem_wr    = 4'b0001,
    e_bedrock_mem_uc_rd = 4'b0010,
    e_bedrock_mem_uc_wr = 4'b0011,
    e_bedrock_mem_pre   = 4'b0100,
    e_bedrock_mem_amo   = 4'b0101
  } bp_bedrock_mem_type_e;
  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'b000,
    e_bedrock_msg_size_2   = 3'b001,
    e_bedrock_msg_size_4   = 3'b010,
    e_bedrock_msg_size_8   = 3'b011,
    e_bedrock_msg_size_16  = 3'b100,
    e_bedrock_msg_size_32  = 3'b101,
    e_bedrock_msg_size_64  = 3'b110,
    e_bedrock_msg_size_128 = 3'b111
  } bp_bedrock_msg_size_e;
  typedef enum logic [1:0] {e_ready, e_wait, e_resp} bp_mem_responder_state_e;
  typedef struct packed {
    logic [mem_payload_width_gp-1:0] payload;
    bp_bedrock_msg_size_e size;
    logic [paddr_width_gp-1:0] addr;
    bp_bedrock_mem_type_e msg_type;
  } bp_bedrock_mem_header_s;
  typedef struct packed {
    logic [cce_block_width_gp-1:0] data;
    bp_bedrock_mem_header_s header;
  } bp_bedrock_mem_msg_s;
  localparam int cce_mem_msg_width_gp = $bits(bp_bedrock_mem_msg_s);
  function automatic logic [lg_block_bytes_gp-1:0] size_lo(bp_bedrock_msg_size_e s);
    return (int'(s) >= lg_block_bytes_gp) ? '1 : lg_block_bytes_gp'((1 << int'(s)) - 1);
  endfunction
  function automatic logic [block_bytes_gp-1:0] byte_mask(bp_bedrock_msg_size_e s, logic [lg_block_bytes_gp-1:0] off);
    logic [block_bytes_gp-1:0] m;
    logic [lg_block_bytes_gp-1:0] lo;
    lo = size_lo(s);
    for (int i = 0; i < block_bytes_gp; i++) m[i] = ((lg_block_bytes_gp'(i) ^ off) & ~lo) == '0;
    return m;
  endfunction
  function automatic logic [cce_block_width_gp-1:0] replicate(logic [cce_block_width_gp-1:0] d, bp_bedrock_msg_size_e s, logic [lg_block_bytes_gp-1:0] off);
    logic [cce_block_width_gp-1:0] r;
    logic [lg_block_bytes_gp-1:0] lo, src;
    lo = size_lo(s);
    for (int i = 0; i < block_bytes_gp; i++) begin
      src = (off & ~lo) | (lg_block_bytes_gp'(i) & lo);
      r[8*i+:8] = d[8*src+:8];
    end
    return r;
  endfunction
endpackage

// File: rtl/bp_fe_icache_mem_responder_storage.sv
// bp_fe_icache_mem_responder_storage: 1rw sync byte-masked block store with base/size range check
module bp_fe_icache_mem_responder_storage
  import bp_me_pkg::*;
#(
  parameter int mem_els_p = 1024,
  parameter logic [paddr_width_gp-1:0] base_addr_p = paddr_width_gp'('h8000_0000)
) (
  input  logic clk_i,
  input  logic v_i,
  input  logic w_i,
  input  logic [paddr_width_gp-1:0] addr_i,
  input  logic [cce_block_width_gp-1:0] data_i,
  input  logic [block_bytes_gp-1:0] mask_i,
  output logic [cce_block_width_gp-1:0] data_o
);
  localparam int lg_els_lp = $clog2(mem_els_p);
  localparam logic [paddr_width_gp-1:0] limit_lp = paddr_width_gp'(mem_els_p) << lg_block_bytes_gp;
  logic [cce_block_width_gp-1:0] mem [mem_els_p];
  logic [cce_block_width_gp-1:0] data_r, bit_mask;
  logic [paddr_width_gp-1:0] off;
  logic [lg_els_lp-1:0] idx;
  logic in_range, hit_r;
  always_comb begin
    off = addr_i - base_addr_p;
    in_range = (addr_i >= base_addr_p) && (off < limit_lp);
    idx = off[lg_block_bytes_gp+:lg_els_lp];
    for (int i = 0; i < block_bytes_gp; i++) bit_mask[8*i+:8] = {8{mask_i[i]}};
  end
  always_ff @(posedge clk_i) begin
    if (v_i & ~w_i) begin
      data_r <= mem[idx];
      hit_r <= in_range;
    end
    if (v_i & w_i & in_range) mem[idx] <= (mem[idx] & ~bit_mask) | (data_i & bit_mask);
  end
  assign data_o = hit_r ? data_r : '0;
endmodule

// File: rtl/bp_fe_icache_mem_responder.sv
// bp_fe_icache_mem_responder: single-outstanding BedRock lite mem responder; BP_FE_MEM_RESP_STALL_EN adds LFSR stalls
module bp_fe_icache_mem_responder
  import bp_me_pkg::*;
#(
  parameter int mem_els_p = 1024,
  parameter logic [paddr_width_gp-1:0] base_addr_p = paddr_width_gp'('h8000_0000),
  parameter int latency_p = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic [cce_mem_msg_width_gp-1:0] mem_cmd_i,
  input  logic mem_cmd_v_i,
  output logic mem_cmd_ready_o,
  output logic [cce_mem_msg_width_gp-1:0] mem_resp_o,
  output logic mem_resp_v_o,
  input  logic mem_resp_yumi_i
);
  bp_mem_responder_state_e state_r, state_n;
  bp_bedrock_mem_msg_s cmd, resp;
  bp_bedrock_mem_header_s hdr_r;
  logic [15:0] cnt_r, lat;
  logic [cce_block_width_gp-1:0] rdata;
  logic accept, stall, cmd_rd, cmd_wr;
  assign cmd = mem_cmd_i;
  assign accept = mem_cmd_v_i & mem_cmd_ready_o;
  assign cmd_rd = cmd.header.msg_type inside {e_bedrock_mem_rd, e_bedrock_mem_uc_rd};
  assign cmd_wr = cmd.header.msg_type inside {e_bedrock_mem_wr, e_bedrock_mem_uc_wr};
`ifdef BP_FE_MEM_RESP_STALL_EN
  logic [7:0] lfsr_r;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) lfsr_r <= 8'h5a;
    else lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
  assign lat = 16'(latency_p) + 16'(lfsr_r[3:1]);
  assign stall = lfsr_r[0];
`else
  assign lat = 16'(latency_p);
  assign stall = 1'b0;
`endif
  bp_fe_icache_mem_responder_storage #(
    .mem_els_p(mem_els_p),
    .base_addr_p(base_addr_p)
  ) storage (
    .clk_i(clk_i),
    .v_i(accept & (cmd_rd | cmd_wr)),
    .w_i(cmd_wr),
    .addr_i(cmd.header.addr),
    .data_i(replicate(cmd.data, cmd.header.size, '0)),
    .mask_i(byte_mask(cmd.header.size, cmd.header.addr[lg_block_bytes_gp-1:0])),
    .data_o(rdata)
  );
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_r <= e_ready;
      hdr_r <= '0;
      cnt_r <= '0;
    end else begin
      state_r <= state_n;
      if (accept) hdr_r <= cmd.header;
      cnt_r <= accept ? ((lat == '0) ? '0 : lat - 16'd1)
             : (state_r == e_wait && cnt_r != '0) ? cnt_r - 16'd1 : cnt_r;
    end
  always_comb
    state_n = (state_r == e_ready) ? (accept ? ((lat == '0) ? e_resp : e_wait) : e_ready)
            : (state_r == e_wait) ? ((cnt_r == '0) ? e_resp : e_wait)
            : (state_r == e_resp) ? (mem_resp_yumi_i ? e_ready : e_resp)
            : e_ready;
  always_comb begin
    mem_cmd_ready_o = ~reset_i & (state_r == e_ready) & ~stall;
    mem_resp_v_o = state_r == e_resp;
    resp.header = hdr_r;
    resp.data = (hdr_r.msg_type inside {e_bedrock_mem_rd, e_bedrock_mem_uc_rd})
              ? replicate(rdata, hdr_r.size, hdr_r.addr[lg_block_bytes_gp-1:0]) : '0;
    mem_resp_o = mem_resp_v_o ? resp : '0;
  end
endmodule

// File: tb/tb_bp_fe_icache_mem_responder.sv
// tb_bp_fe_icache_mem_responder: random and directed checks against a transaction-level memory model
module tb_bp_fe_icache_mem_responder;
  import bp_me_pkg::*;
  localparam int W = cce_mem_msg_width_gp;
  localparam int els = 1024;
  localparam int lat = 4;
  localparam logic [39:0] base = 40'h00_8000_0000;
  logic clk = 0, rst = 1;
  logic [W-1:0] cmd = '0, resp, exp_resp, last;
  logic cmd_v = 0, ready, resp_v, yumi = 0;
  logic [511:0] mm [els];
  int total = 0, bad = 0, cyc = 0, due = 0, acc_cyc = 0, rsp_cyc = 0;
  bit busy = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  bp_fe_icache_mem_responder dut (
    .clk_i(clk),
    .reset_i(rst),
    .mem_cmd_i(cmd),
    .mem_cmd_v_i(cmd_v),
    .mem_cmd_ready_o(ready),
    .mem_resp_o(resp),
    .mem_resp_v_o(resp_v),
    .mem_resp_yumi_i(yumi)
  );
  task automatic chk(input string nm, input logic [W-1:0] a, input logic [W-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  function automatic bit in_rng(input logic [39:0] a);
    return a >= base && ((a - base) >> 6) < 40'(els);
  endfunction
  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i+:32] = $urandom;
    return r;
  endfunction
  function automatic logic [39:0] blk_addr(input int k);
    return base + 40'((k < 8 ? k : els - 1) * 64);
  endfunction
  function automatic logic [39:0] oor_addr();
    int k;
    k = $urandom % 3;
    return k == 0 ? 40'h1000 + 40'($urandom % 256)
         : k == 1 ? 40'($urandom % 32'h8000_0000)
         : base + 40'(els * 64) + 40'($urandom % 4096);
  endfunction
  function automatic logic [W-1:0] model_step(input logic [W-1:0] c);
    bp_bedrock_mem_msg_s m, r;
    int nb, start, idx;
    m = c;
    r.header = m.header;
    r.data = '0;
    nb = (int'(m.header.size) >= 6) ? 64 : (1 << int'(m.header.size));
    start = (int'(m.header.addr[5:0]) / nb) * nb;
    if (in_rng(m.header.addr)) begin
      idx = int'((m.header.addr - base) >> 6);
      if (m.header.msg_type == e_bedrock_mem_rd || m.header.msg_type == e_bedrock_mem_uc_rd)
        for (int i = 0; i < 64; i++) r.data[8*i+:8] = mm[idx][8*(start + i % nb)+:8];
      else if (m.header.msg_type == e_bedrock_mem_wr || m.header.msg_type == e_bedrock_mem_uc_wr)
        for (int j = 0; j < nb; j++) mm[idx][8*(start + j)+:8] = m.data[8*j+:8];
    end
    return r;
  endfunction
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready", W'(ready), '0);
      chk("rst_resp_v", W'(resp_v), '0);
      busy = 0;
    end else begin
      chk("ready", W'(ready), W'(!busy));
      chk("resp_v", W'(resp_v), W'(busy && cyc >= due));
      if (busy && cyc >= due) begin
        chk("resp", resp, exp_resp);
        if (yumi) busy = 0;
      end else if (!busy && cmd_v) begin
        exp_resp = model_step(cmd);
        busy = 1;
        due = cyc + lat + 1;
      end
    end
  end
  task automatic issue(input bp_bedrock_mem_type_e t, input bp_bedrock_msg_size_e s, input logic [39:0] a, input logic [511:0] d, input bit junk);
    bp_bedrock_mem_msg_s m;
    int n;
    m.header.msg_type = t;
    m.header.size = s;
    m.header.addr = a;
    m.header.payload = 16'($urandom);
    m.data = d;
    cmd = m;
    cmd_v = 1;
    n = 0;
    @(negedge clk);
    while (!ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("accept", W'(ready), W'(1));
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    m.header.msg_type = e_bedrock_mem_wr;
    m.header.addr = base;
    m.data = rand512();
    cmd = m;
    cmd_v = junk;
  endtask
  task automatic complete(input int hold);
    int n;
    n = 0;
    @(negedge clk);
    while (!resp_v && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("resp_arrive", W'(resp_v), W'(1));
    rsp_cyc = cyc;
    last = resp;
    repeat (hold) @(negedge clk);
    @(posedge clk);
    #1;
    yumi = resp_v;
    cmd_v = 0;
    @(posedge clk);
    #1;
    yumi = 0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  initial begin
    logic [511:0] blk, blk2;
    bp_bedrock_mem_msg_s lm;
    repeat (5) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("ready_after_reset", W'(ready), W'(1));
    @(posedge clk);
    #1;
    for (int k = 0; k < 9; k++) begin
      issue(e_bedrock_mem_wr, e_bedrock_msg_size_64, blk_addr(k), rand512(), 0);
      complete(0);
    end
    for (int i = 0; i < 64; i++) blk[8*i+:8] = 8'(64 - i);
    issue(e_bedrock_mem_wr, e_bedrock_msg_size_64, base + 40'h40, blk, 0);
    complete(0);
    issue(e_bedrock_mem_rd, e_bedrock_msg_size_64, base + 40'h40, rand512(), 0);
    complete(0);
    lm = last;
    chk("blk_rd_data", W'(lm.data), W'(blk));
    chk("blk_rd_type", W'(lm.header.msg_type), W'(e_bedrock_mem_rd));
    chk("blk_rd_addr", W'(lm.header.addr), W'(40'h00_8000_0040));
    issue(e_bedrock_mem_uc_wr, e_bedrock_msg_size_8, base + 40'h48, 512'(64'hDEAD_BEEF_0000_0001), 0);
    complete(0);
    lm = last;
    chk("uc_wr_data", W'(lm.data), '0);
    issue(e_bedrock_mem_uc_rd, e_bedrock_msg_size_8, base + 40'h48, '0, 0);
    complete(0);
    lm = last;
    chk("uc_rd_data", W'(lm.data), W'({8{64'hDEAD_BEEF_0000_0001}}));
    blk2 = blk;
    blk2[127:64] = 64'hDEAD_BEEF_0000_0001;
    issue(e_bedrock_mem_rd, e_bedrock_msg_size_64, base + 40'h40, '0, 0);
    complete(0);
    lm = last;
    chk("blk_after_uc", W'(lm.data), W'(blk2));
    issue(e_bedrock_mem_rd, e_bedrock_msg_size_4, base + 40'h44, '0, 1);
    complete(2);
    chk("latency", W'(rsp_cyc - acc_cyc), W'(5));
    @(negedge clk);
    chk("ready_after_yumi", W'(ready), W'(1));
    chk("ready_cycle", W'(cyc - rsp_cyc), W'(4));
    @(posedge clk);
    #1;
    issue(e_bedrock_mem_rd, e_bedrock_msg_size_64, 40'h1000, '0, 0);
    complete(0);
    lm = last;
    chk("oor_rd_data", W'(lm.data), '0);
    issue(e_bedrock_mem_wr, e_bedrock_msg_size_64, base + 40'(els * 64), rand512(), 0);
    complete(0);
    for (int k = 0; k < 9; k++) begin
      issue(e_bedrock_mem_rd, e_bedrock_msg_size_64, blk_addr(k), '0, 0);
      complete(0);
    end
    issue(e_bedrock_mem_wr, e_bedrock_msg_size_8, base + 40'h80, 512'(64'h1122_3344_5566_7788), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(posedge clk);
    #1;
    issue(e_bedrock_mem_uc_rd, e_bedrock_msg_size_8, base + 40'h80, '0, 0);
    complete(0);
    lm = last;
    chk("after_reset_rd", W'(lm.data), W'({8{64'h1122_3344_5566_7788}}));
    for (int t = 0; t < 250; t++) begin
      int r, g;
      bp_bedrock_mem_type_e ty;
      logic [39:0] a;
      r = $urandom % 10;
      ty = r < 3 ? e_bedrock_mem_rd : r < 5 ? e_bedrock_mem_uc_rd : r < 7 ? e_bedrock_mem_wr
         : r < 9 ? e_bedrock_mem_uc_wr : (($urandom % 2) == 0 ? e_bedrock_mem_pre : e_bedrock_mem_amo);
      a = (($urandom % 8) == 0) ? oor_addr() : blk_addr($urandom % 9) + 40'($urandom % 64);
      issue(ty, bp_bedrock_msg_size_e'(3'($urandom)), a, rand512(), ($urandom % 4) == 0);
      complete($urandom % 3);
      g = $urandom % 3;
      repeat (g) begin
        @(posedge clk);
        #1;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
